// File: rtl/simon_sequence_store.sv
// Purpose: grows a Simon game sequence of 2-bit symbols, plays it back with
//          timed on/off phases, then checks player guesses against it.
// Latency: the first shown symbol appears the cycle after i_Start_Show is sampled.
//          Win/fail pulses appear the cycle after the deciding guess.
// Backpressure: none. Pulses arriving outside their accepting state are dropped.
//
// Ports:
//   i_Clk, i_Rst          clock, synchronous active-high reset
//   i_LFSR_Data           random word; bits [1:0] become the appended symbol
//   i_Add_Step            append one symbol (IDLE only, ignored when full)
//   i_Start_Show          start playback (IDLE only, needs length > 0)
//   i_Guess_Valid/Value   player guess (WAIT_GUESS only)
//   i_Clear               abort from any state and empty the sequence
//   o_Show_Active/Value   symbol currently displayed
//   o_Busy                state != IDLE
//   o_Length, o_Full      current sequence length, length == MAX_LEN
//   o_Round_Win/Fail      1-cycle registered result pulses
module simon_sequence_store #(
  parameter int LFSR_BITS  = 8,
  parameter int MAX_LEN    = 16,
  parameter int STEP_TICKS = 6250000,
  parameter int GAP_TICKS  = 2500000
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic [LFSR_BITS-1:0]         i_LFSR_Data,
  input  logic                         i_Add_Step,
  input  logic                         i_Start_Show,
  input  logic                         i_Guess_Valid,
  input  logic [1:0]                   i_Guess_Value,
  input  logic                         i_Clear,
  output logic                         o_Show_Active,
  output logic [1:0]                   o_Show_Value,
  output logic                         o_Busy,
  output logic [$clog2(MAX_LEN+1)-1:0] o_Length,
  output logic                         o_Full,
  output logic                         o_Round_Win,
  output logic                         o_Round_Fail
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MAXT = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
  localparam int CW   = ($clog2(MAXT) > 0) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_GUESS
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   show_idx_q, show_idx_d;
  logic [LW-1:0]   guess_idx_q, guess_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            win_q, win_d;
  logic            fail_q, fail_d;
  logic            wr_en;
  logic            full;
  logic [1:0]      seq_q [MAX_LEN];

  // Only bits [1:0] of the random word are meaningful here.
  logic lfsr_unused;
  assign lfsr_unused = ^i_LFSR_Data;

  assign full = (len_q == LEN_MAX);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    show_idx_d  = show_idx_q;
    guess_idx_d = guess_idx_q;
    cnt_d       = cnt_q;
    win_d       = 1'b0;
    fail_d      = 1'b0;
    wr_en       = 1'b0;

    if (i_Clear) begin
      state_d     = S_IDLE;
      len_d       = '0;
      show_idx_d  = '0;
      guess_idx_d = '0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_Add_Step && !full) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_ONE;
          end
          // Checked against len_d so a same-cycle append can start playback
          // from an empty sequence.
          if (i_Start_Show && (len_d != '0)) begin
            state_d    = S_SHOW_ON;
            show_idx_d = '0;
            cnt_d      = '0;
          end
        end

        S_SHOW_ON: begin
          if (cnt_q == STEP_LAST) begin
            state_d = S_SHOW_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_SHOW_OFF: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d      = '0;
            show_idx_d = show_idx_q + LEN_ONE;
            if ((show_idx_q + LEN_ONE) == len_q) begin
              state_d     = S_WAIT_GUESS;
              guess_idx_d = '0;
            end else begin
              state_d = S_SHOW_ON;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_WAIT_GUESS: begin
          if (i_Guess_Valid) begin
            if (i_Guess_Value == seq_q[guess_idx_q[IW-1:0]]) begin
              if ((guess_idx_q + LEN_ONE) == len_q) begin
                win_d       = 1'b1;
                state_d     = S_IDLE;
                guess_idx_d = '0;
              end else begin
                guess_idx_d = guess_idx_q + LEN_ONE;
              end
            end else begin
              fail_d      = 1'b1;
              len_d       = '0;
              guess_idx_d = '0;
              state_d     = S_IDLE;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      show_idx_q  <= '0;
      guess_idx_q <= '0;
      cnt_q       <= '0;
      win_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      show_idx_q  <= show_idx_d;
      guess_idx_q <= guess_idx_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      fail_q      <= fail_d;
    end
  end

  // Symbol storage is deliberately not reset; only entries below len_q are read.
  always_ff @(posedge i_Clk) begin
    if (wr_en && !i_Rst) begin
      seq_q[len_q[IW-1:0]] <= i_LFSR_Data[1:0];
    end
  end

  always_comb begin
    o_Show_Active = (state_q == S_SHOW_ON);
    o_Show_Value  = 2'b00;
    if (state_q == S_SHOW_ON) begin
      o_Show_Value = seq_q[show_idx_q[IW-1:0]];
    end
  end

  assign o_Busy       = (state_q != S_IDLE);
  assign o_Length     = len_q;
  assign o_Full       = full;
  assign o_Round_Win  = win_q;
  assign o_Round_Fail = fail_q;

endmodule

// File: doc/simon_sequence_store.md
Name: simon_sequence_store

Overview:
- Consumes the pseudo-random word from the LFSR stage and turns it into a growing game sequence of 2-bit symbols (one per LED/button).
- Stores up to MAX_LEN symbols and plays the sequence back with timed on/off phases.
- Then checks the player's guesses against the stored sequence and reports win or fail for the round.

Parameters:
- LFSR_BITS, 8, width of i_LFSR_Data.
- MAX_LEN, 16, maximum stored sequence length (≥2).
- STEP_TICKS, 6250000, clock cycles a symbol is shown (≥1).
- GAP_TICKS, 2500000, blank clock cycles after each shown symbol (≥1).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset.
- i_LFSR_Data  in  LFSR_BITS  free-running random word from the LFSR stage; bits [1:0] are used.
- i_Add_Step  in  1  pulse: append one random symbol.
- i_Start_Show  in  1  pulse: start playback.
- i_Guess_Valid  in  1  pulse: player pressed a button.
- i_Guess_Value  in  2  button index of the guess.
- i_Clear  in  1  pulse: abort and empty the sequence.
- o_Show_Active  out  1  high while a symbol is displayed.
- o_Show_Value  out  2  symbol being displayed (valid when o_Show_Active).
- o_Busy  out  1  high in any state other than IDLE.
- o_Length  out  clog2(MAX_LEN+1)  current sequence length.
- o_Full  out  1  o_Length == MAX_LEN.
- o_Round_Win  out  1  1-cycle pulse: full sequence guessed correctly.
- o_Round_Fail  out  1  1-cycle pulse: wrong guess.

Behaviour:
- Interface: one clock, i_Clk. Reset i_Rst is synchronous and active-high.
- Reset: state IDLE; length, show index, guess index, tick counter = 0; all outputs 0.
- Storage: MAX_LEN x 2-bit register array, written at index o_Length. Contents are not cleared on reset; only entries below o_Length are ever read.
- States: IDLE, SHOW_ON, SHOW_OFF, WAIT_GUESS.
- Priority each cycle: i_Rst > i_Clear > state logic.
- i_Clear, any state: next state IDLE, length/indices/counter = 0. No win/fail pulse.
- IDLE, i_Add_Step:
  - If length < MAX_LEN: store i_LFSR_Data[1:0] at seq[length], length+1 on the next edge.
  - If full: ignored, o_Full stays 1.
- IDLE, i_Start_Show with length > 0: next state SHOW_ON, show index 0, counter 0. Ignored if length == 0.
- i_Add_Step and i_Start_Show in the same IDLE cycle: the append happens and playback uses the updated length. Length 0 plus both pulses plays one symbol.
- SHOW_ON:
  - o_Show_Active = 1, o_Show_Value = seq[show index].
  - Lasts exactly STEP_TICKS cycles, then SHOW_OFF with counter 0.
- SHOW_OFF:
  - o_Show_Active = 0, o_Show_Value = 0.
  - Lasts exactly GAP_TICKS cycles, then show index+1.
  - If the new index == length: go to WAIT_GUESS with guess index 0. Otherwise go to SHOW_ON.
- First o_Show_Active cycle is the cycle after i_Start_Show is sampled.
- WAIT_GUESS, on i_Guess_Valid:
  - If i_Guess_Value == seq[guess index] and it is the last index: o_Round_Win pulse next cycle, go to IDLE, length kept.
  - If correct and not the last index: guess index+1.
  - If incorrect: o_Round_Fail pulse next cycle, length = 0, go to IDLE.
- Pulses are exactly 1 cycle, registered, and asserted in the cycle the state shows IDLE.
- Inputs outside their accepting state are ignored: i_Guess_Valid outside WAIT_GUESS, i_Add_Step and i_Start_Show outside IDLE.
- No guess timeout in this block; that belongs to the game controller.
- o_Busy = (state != IDLE).
- o_Full is combinational from length.
- Counters never wrap. Tick counter width is clog2(max(STEP_TICKS, GAP_TICKS)).
- o_Length width holds MAX_LEN exactly.

Test Plan (STEP_TICKS=4, GAP_TICKS=2, MAX_LEN=4):
- Reset, then i_Add_Step x3 with i_LFSR_Data[1:0] = 2,0,3 -> o_Length=3, o_Full=0, o_Busy=0.
- From that state, pulse i_Start_Show -> o_Show_Active high 4 cycles with value 2, low 2, high 4 with 0, low 2, high 4 with 3, low 2, then WAIT_GUESS. Total 18 cycles, first high 1 cycle after the pulse.
- Guesses 2,0,3 -> o_Round_Win 1-cycle pulse one cycle after the third guess, o_Length=3, o_Busy=0.
- Repeat playback, then guesses 2,1 -> o_Round_Fail pulse after the second guess, o_Length=0; a further i_Guess_Valid gives no pulse.
- Add 5 steps -> o_Length=4 and o_Full=1 after the fourth; the fifth is ignored. i_Start_Show and i_Add_Step in the same cycle from empty -> one symbol shown, o_Length=1.
- Mid-SHOW_ON assert i_Clear -> o_Show_Active=0 next cycle, o_Length=0, o_Busy=0. Repeat with i_Rst mid-WAIT_GUESS -> all outputs 0, no pulses.
